// File: rtl/adder_pipe.sv
// adder_pipe: pipelined two's-complement adder/subtractor with a valid/ready
// handshake and status flags. Operands are split into SEG-bit segments; each
// stage resolves one segment and registers its carry for the next stage.
// An input register level captures the operand set, followed by STAGES
// segment stages; the last stage writes the output register, so a result
// appears STAGES clock edges after its operands are accepted.
// Optional feature: define ADDER_PIPE_SAT_EN to clamp the sum on signed
// overflow instead of wrapping.
module adder_pipe #(
  parameter int WIDTH = 30,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int STAGES = (WIDTH + SEG - 1) / SEG;
  localparam int L      = STAGES - 1;
  localparam int WW     = WIDTH + 1;

  // Level k holds an entry waiting for segment k to be resolved. Operands
  // travel unchanged (b already inverted for subtract); lv_s accumulates the
  // completed lower sum segments.
  logic [WIDTH-1:0] lv_a [STAGES];
  logic [WIDTH-1:0] lv_b [STAGES];
  logic [WIDTH-1:0] lv_s [STAGES];
  logic             lv_c [STAGES];
  logic             lv_v [STAGES];

  logic [WIDTH-1:0] nx_s [STAGES];
  logic             nx_c [STAGES];

  logic [WIDTH-1:0] fin_sum;
  logic             fin_ovf;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  logic             adv;

  // The whole pipe moves together; it stalls only when a result is waiting
  // and the consumer refuses it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Per-stage segment ripple; the last segment may be narrower than SEG.
  always_comb begin
    logic [WW-1:0] mask;
    logic [WW-1:0] x;
    logic [WW-1:0] y;
    logic [WW-1:0] t;
    logic [WW-1:0] placed;
    logic [WW-1:0] carry_v;
    int            lo;
    int            w;
    mask    = '0;
    x       = '0;
    y       = '0;
    t       = '0;
    placed  = '0;
    carry_v = '0;
    lo      = 0;
    w       = 0;
    for (int k = 0; k < STAGES; k++) begin
      lo        = k * SEG;
      w         = (k == L) ? (WIDTH - lo) : SEG;
      mask      = {WW{1'b1}} >> (WW - w);
      x         = ({1'b0, lv_a[k]} >> lo) & mask;
      y         = ({1'b0, lv_b[k]} >> lo) & mask;
      t         = x + y + {{WIDTH{1'b0}}, lv_c[k]};
      carry_v   = t >> w;
      nx_c[k]   = carry_v[0];
      placed    = (t & mask) << lo;
      nx_s[k]   = lv_s[k] | placed[WIDTH-1:0];
    end
  end

  // Final flags: signed overflow when both addends share a sign that the
  // result does not (equivalent to carry-in XOR carry-out of the MSB).
  always_comb begin
    fin_sum = nx_s[L];
    fin_ovf = (lv_a[L][WIDTH-1] == lv_b[L][WIDTH-1]) &&
              (nx_s[L][WIDTH-1] != lv_a[L][WIDTH-1]);
`ifdef ADDER_PIPE_SAT_EN
    if (fin_ovf) begin
      fin_sum = lv_a[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    fin_sum = nx_s[L];
`endif
  end

  // Valid bits: cleared by reset so no in-flight entry survives it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        lv_v[k] <= 1'b0;
      end
      out_valid <= 1'b0;
    end else if (adv) begin
      lv_v[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        lv_v[k] <= lv_v[k-1];
      end
      out_valid <= lv_v[L];
    end
  end

  // Data path registers: no reset needed, outputs are masked by out_valid.
  always_ff @(posedge clk) begin
    if (adv) begin
      lv_a[0] <= a;
      lv_b[0] <= sub ? ~b : b;
      lv_c[0] <= sub | cin;
      lv_s[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        lv_a[k] <= lv_a[k-1];
        lv_b[k] <= lv_b[k-1];
        lv_s[k] <= nx_s[k-1];
        lv_c[k] <= nx_c[k-1];
      end
      r_sum  <= fin_sum;
      r_cout <= nx_c[L];
      r_ovf  <= fin_ovf;
      r_zero <= (fin_sum == '0);
      r_neg  <= fin_sum[WIDTH-1];
    end
  end

  // Outputs read as zero whenever no result is present.
  assign sum      = out_valid ? r_sum : '0;
  assign cout     = out_valid & r_cout;
  assign overflow = out_valid & r_ovf;
  assign zero     = out_valid & r_zero;
  assign negative = out_valid & r_neg;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed checks on the SEG=8 build plus a randomized
// sweep over SEG=8, SEG=30 and SEG=7 builds against an arithmetic model.
module tb_adder_pipe;

  localparam int W = 30;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
    logic         n;
  } res_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         in_ready_o  [3];
  logic         out_valid_o [3];
  logic [W-1:0] sum_o       [3];
  logic         cout_o      [3];
  logic         ovf_o       [3];
  logic         zero_o      [3];
  logic         neg_o       [3];

  int errors = 0;
  int checks = 0;

  res_t q0[$];
  res_t q1[$];
  res_t q2[$];

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(W), .SEG(8)) u8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_o[0]),
    .out_ready(out_ready), .sum(sum_o[0]), .cout(cout_o[0]),
    .overflow(ovf_o[0]), .zero(zero_o[0]), .negative(neg_o[0]));

  adder_pipe #(.WIDTH(W), .SEG(30)) u30 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_o[1]),
    .out_ready(out_ready), .sum(sum_o[1]), .cout(cout_o[1]),
    .overflow(ovf_o[1]), .zero(zero_o[1]), .negative(neg_o[1]));

  adder_pipe #(.WIDTH(W), .SEG(7)) u7 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_o[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_o[2]),
    .out_ready(out_ready), .sum(sum_o[2]), .cout(cout_o[2]),
    .overflow(ovf_o[2]), .zero(zero_o[2]), .negative(neg_o[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    res_t         r;
    logic [W-1:0] ny;
    longint       ux, uy, full, lim, sx, sy, ss;
`ifdef ADDER_PIPE_SAT_EN
    longint       cl;
`endif
    ny   = ~y;
    ux   = longint'(x);
    uy   = sb ? longint'(ny) : longint'(y);
    full = ux + uy + ((sb || ci) ? 64'sd1 : 64'sd0);
    r.s  = full[W-1:0];
    r.co = full[W];
    lim  = 64'sd1 <<< (W - 1);
    sx   = x[W-1] ? ux - 2 * lim : ux;
    sy   = y[W-1] ? longint'(y) - 2 * lim : longint'(y);
    ss   = sb ? sx - sy : sx + sy + (ci ? 64'sd1 : 64'sd0);
    r.ov = (ss >= lim) || (ss < -lim);
`ifdef ADDER_PIPE_SAT_EN
    if (r.ov) begin
      cl  = x[W-1] ? lim : lim - 1;
      r.s = cl[W-1:0];
    end
`endif
    r.z = (r.s == '0);
    r.n = r.s[W-1];
    return r;
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int i, input res_t r);
    case (i)
      0:       q0.push_back(r);
      1:       q1.push_back(r);
      default: q2.push_back(r);
    endcase
  endtask

  task automatic qpop(input int i, output res_t r);
    case (i)
      0:       r = q0.pop_front();
      1:       r = q1.pop_front();
      default: r = q2.pop_front();
    endcase
  endtask

  task automatic chk_res(input string tag, input int i, input res_t e);
    chk({tag, " sum"},  64'(sum_o[i]),  64'(e.s));
    chk({tag, " cout"}, 64'(cout_o[i]), 64'(e.co));
    chk({tag, " ovf"},  64'(ovf_o[i]),  64'(e.ov));
    chk({tag, " zero"}, 64'(zero_o[i]), 64'(e.z));
    chk({tag, " neg"},  64'(neg_o[i]),  64'(e.n));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operand set on an idle pipe: checks latency, result and no repeat.
  task automatic issue_one(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                           input logic xc, input logic xs, input res_t e);
    int n;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid_o[0] && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'd4);
    chk_res(tag, 0, e);
    tick();
    chk({tag, " no repeat"}, 64'(out_valid_o[0]), 64'd0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t         e;
    logic [W-1:0] held;
    int           idx, got, extra, vcount;

    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    chk("rst out_valid", 64'(out_valid_o[0]), 64'd0);
    chk("rst sum",       64'(sum_o[0]),       64'd0);
    chk("rst cout",      64'(cout_o[0]),      64'd0);
    chk("rst ovf",       64'(ovf_o[0]),       64'd0);
    chk("rst zero",      64'(zero_o[0]),      64'd0);
    chk("rst neg",       64'(neg_o[0]),       64'd0);
    chk("rst in_ready",  64'(in_ready_o[0]),  64'd1);
    reset_n = 1'b1;
    tick();

    // Wrap to zero
    e = '{s: 30'h0, co: 1'b1, ov: 1'b0, z: 1'b1, n: 1'b0};
    issue_one("wrap", 30'h3FFFFFFF, 30'h0, 1'b1, 1'b0, e);

    // Signed overflow
`ifdef ADDER_PIPE_SAT_EN
    e = '{s: 30'h1FFFFFFF, co: 1'b0, ov: 1'b1, z: 1'b0, n: 1'b0};
`else
    e = '{s: 30'h20000000, co: 1'b0, ov: 1'b1, z: 1'b0, n: 1'b1};
`endif
    issue_one("ovf", 30'h1FFFFFFF, 30'h1, 1'b0, 1'b0, e);

    // Subtract with borrow, cin ignored
    e = '{s: 30'h3FFFFFFE, co: 1'b0, ov: 1'b0, z: 1'b0, n: 1'b1};
    issue_one("sub", 30'd5, 30'd7, 1'b1, 1'b1, e);

    // Streaming with a three-cycle stall
    idx = 0; got = 0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (idx < 10);
      a = W'(idx); b = W'(idx * 3); cin = 1'b0; sub = 1'b0;
      #1;
      if (!out_ready) begin
        chk("stall in_ready",  64'(in_ready_o[0]),  64'd0);
        chk("stall out_valid", 64'(out_valid_o[0]), 64'd1);
        if (cyc == 6) held = sum_o[0];
        else chk("stall hold", 64'(sum_o[0]), 64'(held));
      end
      if (out_valid_o[0] && out_ready) begin
        chk("stream sum",  64'(sum_o[0]),  64'(4 * got));
        chk("stream cout", 64'(cout_o[0]), 64'd0);
        got++;
      end
      if (in_valid && in_ready_o[0]) idx++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream count", 64'(got), 64'd10);
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid_o[0]) extra++;
      tick();
    end
    chk("stream no dup", 64'(extra), 64'd0);

    // Reset mid-flight
    in_valid = 1'b1; a = 30'd100; b = 30'd1; cin = 1'b0; sub = 1'b0;
    tick();
    a = 30'd200;
    tick();
    a = 30'd300; reset_n = 1'b0;
    tick();
    reset_n = 1'b1; in_valid = 1'b0;
    chk("midrst out_valid", 64'(out_valid_o[0]), 64'd0);
    chk("midrst sum",       64'(sum_o[0]),       64'd0);
    chk("midrst cout",      64'(cout_o[0]),      64'd0);
    chk("midrst ovf",       64'(ovf_o[0]),       64'd0);
    chk("midrst zero",      64'(zero_o[0]),      64'd0);
    chk("midrst neg",       64'(neg_o[0]),       64'd0);
    in_valid = 1'b1; a = 30'd400; b = 30'd2;
    tick();
    in_valid = 1'b0;
    vcount = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid_o[0]) begin
        chk("post-rst sum", 64'(sum_o[0]), 64'd402);
        vcount++;
      end
      tick();
    end
    chk("post-rst count", 64'(vcount), 64'd1);

    // Randomized sweep across three segment widths
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    for (int v = 0; v < 1300; v++) begin
      out_ready = ($urandom_range(0, 4) != 0);
      in_valid  = (v < 1000) && ($urandom_range(0, 7) != 0);
      a   = pick();
      b   = pick();
      cin = 1'($urandom);
      sub = 1'($urandom);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (out_valid_o[i] && out_ready) begin
          if (qsize(i) == 0) begin
            chk($sformatf("sweep%0d spurious", i), 64'(out_valid_o[i]), 64'd0);
          end else begin
            qpop(i, e);
            chk_res($sformatf("sweep%0d", i), i, e);
          end
        end
        if (in_valid && in_ready_o[i]) qpush(i, model(a, b, cin, sub));
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sweep%0d drained", i), 64'(qsize(i)), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
